port_writer: RTL and testbench

- Bus master for the 8-bit micro register port: the writing end of the port_in/addr/write interface whose receiver is the display register file.
- On start, snapshots a telemetry record and issues one timed write per enabled field to fixed addresses 0..5.
- Placed in the telemetry/bridge FPGA or test harness, feeding the display board's micro input pins.

---
 rtl/disp_reg_pkg.sv | 23 ++
 rtl/port_writer_if.sv | 9 +
 rtl/port_writer.sv | 131 +++++++++++++
 tb/tb_port_writer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_reg_pkg.sv
// Shared definitions for the micro register port: register addresses, the
// port_writer state encoding and a priority helper used to walk the field mask.
package disp_reg_pkg;

  localparam logic [2:0] ADDR_SPEED     = 3'd0;
  localparam logic [2:0] ADDR_READY     = 3'd1;
  localparam logic [2:0] ADDR_CAR_BATT  = 3'd2;
  localparam logic [2:0] ADDR_DISP_BATT = 3'd3;
  localparam logic [2:0] ADDR_GPS       = 3'd4;
  localparam logic [2:0] ADDR_ERR       = 3'd5;

  localparam int NUM_REGS = 6;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} pw_state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] lowest_set(input logic [NUM_REGS-1:0] m);
    lowest_set = 3'd0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (m[i]) lowest_set = 3'(i);
  endfunction

endpackage

// File: rtl/port_writer_if.sv
// Micro register port bus: 8-bit data, 3-bit address and write strobe.
interface port_writer_if;
  logic [7:0] port_out;
  logic [2:0] addr;
  logic       write;

  modport master (output port_out, addr, write);
  modport slave  (input  port_out, addr, write);
endinterface

// File: rtl/port_writer.sv
// Snapshots a telemetry record on start and issues one setup/strobe/hold
// write per enabled field, in ascending address order.
module port_writer
  import disp_reg_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_REGS-1:0] field_mask,
  input  logic [7:0]          speed,
  input  logic                ready_to_drive,
  input  logic [7:0]          car_battery,
  input  logic [7:0]          disp_battery,
  input  logic [7:0]          gps_status,
  input  logic [7:0]          err_code,
  port_writer_if.master       bus,
  output logic                busy,
  output logic                done
);

  localparam int MAX_SW = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAXC   = (MAX_SW > HOLD_CYCLES) ? MAX_SW : HOLD_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);

  typedef logic [CW-1:0] cnt_t;

  pw_state_t                    state, state_nx;
  cnt_t                         cnt, cnt_ld;
  logic                         cnt_zero;
  logic [NUM_REGS-1:0][7:0]     fields, snap;
  logic [NUM_REGS-1:0]          mask_q, mask_rem, cur_bit;
  logic [2:0]                   addr_q, first_idx, next_idx;
  logic [7:0]                   data_q;
  logic                         wr;

  assign fields[ADDR_SPEED]     = speed;
  assign fields[ADDR_READY]     = {7'd0, ready_to_drive};
  assign fields[ADDR_CAR_BATT]  = car_battery;
  assign fields[ADDR_DISP_BATT] = disp_battery;
  assign fields[ADDR_GPS]       = gps_status;
  assign fields[ADDR_ERR]       = err_code;

  assign cnt_zero  = (cnt == '0);
  assign cur_bit   = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr_q;
  assign mask_rem  = mask_q & ~cur_bit;
  assign first_idx = lowest_set(field_mask);
  assign next_idx  = lowest_set(mask_rem);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (field_mask != '0) ? SETUP : DONE;
      SETUP:   if (cnt_zero) state_nx = STROBE;
      STROBE:  if (cnt_zero) state_nx = HOLD;
      HOLD:    if (cnt_zero) state_nx = (mask_rem != '0) ? SETUP : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    wr   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SETUP:   busy = 1'b1;
      STROBE:  begin busy = 1'b1; wr = 1'b1; end
      HOLD:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Counter reloads with (duration-1) on every state entry, so the state
  // lasts exactly its duration and exits when the count reaches zero.
  always_comb begin
    cnt_ld = '0;
    case (state_nx)
      SETUP:   cnt_ld = cnt_t'(SETUP_CYCLES - 1);
      STROBE:  cnt_ld = cnt_t'(STROBE_CYCLES - 1);
      HOLD:    cnt_ld = cnt_t'(HOLD_CYCLES - 1);
      default: cnt_ld = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state_nx != state) cnt <= cnt_ld;
    else if (!cnt_zero)         cnt <= cnt - cnt_t'(1);
  end

  // Snapshot and bus datapath; addr/data only move on accept or HOLD->SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap   <= '0;
      mask_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (state == IDLE && start) begin
      snap   <= fields;
      mask_q <= field_mask;
      if (field_mask != '0) begin
        addr_q <= first_idx;
        data_q <= fields[first_idx];
      end
    end else if (state == HOLD && cnt_zero) begin
      mask_q <= mask_rem;
      if (mask_rem != '0) begin
        addr_q <= next_idx;
        data_q <= snap[next_idx];
      end
    end
  end

  assign bus.port_out = data_q;
  assign bus.addr     = addr_q;
  assign bus.write    = wr;

endmodule

// File: tb/tb_port_writer.sv
// Directed bench for port_writer: default timing instance plus a 3/1/2 timing instance.
module tb_port_writer;

  logic       clk, rst_n, start, start2;
  logic [5:0] field_mask;
  logic [7:0] speed, car, disp, gps, err;
  logic       ready;
  logic       busy_a, done_a, busy_b, done_b;
  int         checks, errors;

  port_writer_if bus_a ();
  port_writer_if bus_b ();

  port_writer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .field_mask(field_mask),
    .speed(speed), .ready_to_drive(ready), .car_battery(car),
    .disp_battery(disp), .gps_status(gps), .err_code(err),
    .bus(bus_a), .busy(busy_a), .done(done_a)
  );

  port_writer #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start2), .field_mask(field_mask),
    .speed(speed), .ready_to_drive(ready), .car_battery(car),
    .disp_battery(disp), .gps_status(gps), .err_code(err),
    .bus(bus_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; field_mask = '0;
    speed = '0; ready = 1'b0; car = '0; disp = '0; gps = '0; err = '0;
    step(); step();
    checks++;
    if ({bus_a.write, busy_a, done_a, bus_a.addr, bus_a.port_out} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state got w=%b b=%b d=%b a=%h p=%h exp all 0",
               bus_a.write, busy_a, done_a, bus_a.addr, bus_a.port_out);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full;
    logic [7:0] exp [6];
    int busy_n, wr_n, done_at, idx;
    logic exp_w;
    exp[0] = 8'h37; exp[1] = 8'h01; exp[2] = 8'hC8;
    exp[3] = 8'h64; exp[4] = 8'h02; exp[5] = 8'hA5;
    busy_n = 0; wr_n = 0; done_at = 0;
    field_mask = 6'h3F; speed = 8'h37; ready = 1'b1; car = 8'hC8;
    disp = 8'h64; gps = 8'h02; err = 8'hA5; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      start = 1'b0;
      if (busy_a) busy_n++;
      if (bus_a.write) wr_n++;
      if (done_a && done_at == 0) done_at = c;
      if (c <= 24) begin
        idx   = (c - 1) / 4;
        exp_w = ((c - 1) % 4 == 1) || ((c - 1) % 4 == 2);
        checks++;
        if (bus_a.addr !== 3'(idx) || bus_a.port_out !== exp[idx] || bus_a.write !== exp_w) begin
          errors++;
          $display("FAIL full_bus cyc %0d got a=%h p=%h w=%b exp a=%h p=%h w=%b",
                   c, bus_a.addr, bus_a.port_out, bus_a.write, idx, exp[idx], exp_w);
        end
      end
    end
    checks++;
    if (busy_n != 24) begin errors++; $display("FAIL full_busy got %0d exp 24", busy_n); end
    checks++;
    if (wr_n != 12) begin errors++; $display("FAIL full_write_cycles got %0d exp 12", wr_n); end
    checks++;
    if (done_at != 25) begin errors++; $display("FAIL full_done_cycle got %0d exp 25", done_at); end
    checks++;
    if (bus_a.addr !== 3'd5 || bus_a.port_out !== 8'hA5) begin
      errors++;
      $display("FAIL full_bus_hold_after_done got a=%h p=%h exp a=5 p=a5", bus_a.addr, bus_a.port_out);
    end
  endtask

  task automatic test_sparse;
    int busy_n, done_at;
    logic [2:0] ea;
    logic [7:0] ep;
    busy_n = 0; done_at = 0;
    field_mask = 6'b100100; speed = 8'hFF; car = 8'h5A; err = 8'h3C; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = 1'b0;
      if (busy_a) busy_n++;
      if (done_a && done_at == 0) done_at = c;
      checks++;
      if (bus_a.write && bus_a.addr == 3'd0) begin
        errors++;
        $display("FAIL sparse_addr0_strobed cyc %0d got a=0 exp never", c);
      end
      if (c <= 8) begin
        ea = (c <= 4) ? 3'd2 : 3'd5;
        ep = (c <= 4) ? 8'h5A : 8'h3C;
        checks++;
        if (bus_a.addr !== ea || bus_a.port_out !== ep) begin
          errors++;
          $display("FAIL sparse_bus cyc %0d got a=%h p=%h exp a=%h p=%h",
                   c, bus_a.addr, bus_a.port_out, ea, ep);
        end
      end
    end
    checks++;
    if (busy_n != 8) begin errors++; $display("FAIL sparse_busy got %0d exp 8", busy_n); end
    checks++;
    if (done_at != 9) begin errors++; $display("FAIL sparse_done_cycle got %0d exp 9", done_at); end
  endtask

  task automatic test_zero_mask;
    field_mask = 6'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || bus_a.write !== 1'b0) begin
      errors++;
      $display("FAIL zero_mask_c1 got d=%b b=%b w=%b exp d=1 b=0 w=0", done_a, busy_a, bus_a.write);
    end
    step();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || bus_a.write !== 1'b0) begin
      errors++;
      $display("FAIL zero_mask_c2 got d=%b b=%b w=%b exp all 0", done_a, busy_a, bus_a.write);
    end
  endtask

  task automatic test_ignore_start;
    int done_n, done_at;
    done_n = 0; done_at = 0;
    field_mask = 6'b000100; car = 8'h10; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      start = (c == 2);
      if (c == 1) car = 8'h20;
      if (done_a) begin done_n++; if (done_at == 0) done_at = c; end
      if (bus_a.write) begin
        checks++;
        if (bus_a.port_out !== 8'h10) begin
          errors++;
          $display("FAIL ignore_data cyc %0d got %h exp 10", c, bus_a.port_out);
        end
      end
    end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", done_n); end
    checks++;
    if (done_at != 5) begin errors++; $display("FAIL ignore_done_cycle got %0d exp 5", done_at); end
  endtask

  task automatic test_timing;
    int done_at;
    logic exp_w;
    done_at = 0;
    field_mask = 6'b000010; ready = 1'b1; start2 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start2 = 1'b0;
      if (done_b && done_at == 0) done_at = c;
      if (c <= 6) begin
        exp_w = (c == 4);
        checks++;
        if (bus_b.addr !== 3'd1 || bus_b.port_out !== 8'h01 || bus_b.write !== exp_w || busy_b !== 1'b1) begin
          errors++;
          $display("FAIL timing_bus cyc %0d got a=%h p=%h w=%b b=%b exp a=1 p=01 w=%b b=1",
                   c, bus_b.addr, bus_b.port_out, bus_b.write, busy_b, exp_w);
        end
      end
    end
    checks++;
    if (done_at != 7) begin errors++; $display("FAIL timing_done_cycle got %0d exp 7", done_at); end
  endtask

  task automatic test_reset_mid;
    field_mask = 6'h3F; speed = 8'h37; start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (bus_a.write !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_strobe got w=%b exp 1", bus_a.write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.write !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async got w=%b b=%b d=%b exp all 0", bus_a.write, busy_a, done_a);
    end
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if ({bus_a.write, busy_a, done_a, bus_a.addr, bus_a.port_out} !== 14'd0) begin
        errors++;
        $display("FAIL mid_post_idle cyc %0d got w=%b b=%b d=%b a=%h p=%h exp all 0",
                 c, bus_a.write, busy_a, done_a, bus_a.addr, bus_a.port_out);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full();
    test_sparse();
    test_zero_mask();
    test_ignore_start();
    test_timing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
